// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared constants, digit index type and helper functions for
//               the four-digit seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam int          DIGIT_W    = 4;
    localparam int          DISP_W     = NUM_DIGITS * DIGIT_W;
    localparam logic [3:0]  AN_OFF     = 4'b1111;
    localparam logic [3:0]  AN_DIG0    = 4'b1110;
    localparam logic [3:0]  AN_DIG1    = 4'b1101;
    localparam logic [3:0]  AN_DIG2    = 4'b1011;
    localparam logic [3:0]  AN_DIG3    = 4'b0111;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_idx_t;

    function automatic logic [3:0] digit_anode(input digit_idx_t idx);
        logic [3:0] v;
        v = AN_OFF;
        unique case (idx)
            DIG0: v = AN_DIG0;
            DIG1: v = AN_DIG1;
            DIG2: v = AN_DIG2;
            DIG3: v = AN_DIG3;
        endcase
        return v;
    endfunction

    function automatic logic [DIGIT_W-1:0] digit_value(input logic [DISP_W-1:0] disp,
                                                       input digit_idx_t        idx);
        logic [DISP_W-1:0] shifted;
        shifted = disp >> (DIGIT_W * int'(idx));
        return shifted[DIGIT_W-1:0];
    endfunction

    // A digit is a leading zero when it and every digit above it are zero;
    // the rightmost digit always stays lit.
    function automatic logic is_leading_zero(input logic [DISP_W-1:0] disp,
                                             input digit_idx_t        idx);
        logic [DISP_W-1:0] upper;
        upper = disp >> (DIGIT_W * int'(idx));
        return (idx != DIG0) && (upper == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : refresh_prescaler
// Description : Free-running 0..DIV-1 counter emitting a tick on the last count.
// Revision    : 1.0 - initial release
// ============================================================================
module refresh_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  c_last = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    assign tick = (r_count == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scan.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan
// Description : Four-digit multiplexed seven-segment scanner with frame-
//               synchronous display update and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DISP_W-1:0]   din,
    input  logic                blank_lz,
    output logic [DIGIT_W-1:0]  bcd,
    output logic [3:0]          an,
    output logic                frame_done
);

    logic               w_tick;
    logic               w_boundary;
    digit_idx_t         r_idx;
    digit_idx_t         w_idx_next;
    logic [DISP_W-1:0]  r_disp;
    logic [DISP_W-1:0]  w_disp_next;
    logic [DISP_W-1:0]  r_pending;
    logic               r_pend_valid;
    logic               w_blank;

    refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_boundary = w_tick && (r_idx == DIG3);
    assign w_idx_next = w_tick ? digit_idx_t'(r_idx + 2'd1) : r_idx;

    // New content only lands on a frame boundary, so a frame never mixes
    // old and new digits; a load on the boundary itself bypasses pending.
    always_comb begin
        w_disp_next = r_disp;
        if (w_boundary) begin
            if (load) begin
                w_disp_next = din;
            end else if (r_pend_valid) begin
                w_disp_next = r_pending;
            end
        end
    end

    assign w_blank = blank_lz && is_leading_zero(w_disp_next, r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= DIG0;
            r_disp       <= '0;
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
            bcd          <= '0;
            an           <= AN_OFF;
            frame_done   <= 1'b0;
        end else begin
            r_idx  <= w_idx_next;
            r_disp <= w_disp_next;
            if (w_boundary) begin
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pending    <= din;
                r_pend_valid <= 1'b1;
            end
            bcd <= digit_value(w_disp_next, w_idx_next);
            // Anodes stay dark for the first cycle of every slot so the
            // previous digit's segments never ghost onto the new one.
            if (w_tick || w_blank) begin
                an <= AN_OFF;
            end else begin
                an <= digit_anode(r_idx);
            end
            frame_done <= w_boundary;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan
// Description : Scoreboard bench for ssd_scan with REFRESH_DIV=4 and
//               hand-computed per-cycle output expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] din;
    logic        blank_lz;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] bcd;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_seen  = 0;
    int   cur     = 0;

    ssd_scan #(
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .din        (din),
        .blank_lz   (blank_lz),
        .bcd        (bcd),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_total++;
            if ({bcd, an, frame_done} === e) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_%0d: got bcd=%h an=%b fd=%b, expected bcd=%h an=%b fd=%b",
                         n_seen, bcd, an, frame_done, e.bcd, e.an, e.fd);
            end
            n_seen++;
        end
    end

    task automatic push1(input logic [3:0] b, input logic [3:0] a, input logic f);
        exp_t e;
        e.bcd = b;
        e.an  = a;
        e.fd  = f;
        exp_q.push_back(e);
    endtask

    task automatic push_slot(input logic [3:0] b, input logic [3:0] a, input logic f);
        push1(b, 4'b1111, f);
        for (int i = 0; i < 3; i++) push1(b, a, 1'b0);
    endtask

    // ans packs the lit anode pattern per digit as {an3, an2, an1, an0}.
    task automatic push_frame(input logic [15:0] d, input logic [15:0] ans);
        push_slot(d[3:0],   ans[3:0],   1'b1);
        push_slot(d[7:4],   ans[7:4],   1'b0);
        push_slot(d[11:8],  ans[11:8],  1'b0);
        push_slot(d[15:12], ans[15:12], 1'b0);
    endtask

    task automatic push_after_reset();
        push1(4'h0, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) push1(4'h0, 4'b1110, 1'b0);
        push_slot(4'h0, 4'b1101, 1'b0);
        push_slot(4'h0, 4'b1011, 1'b0);
        push_slot(4'h0, 4'b0111, 1'b0);
    endtask

    task automatic at_edge(input int k);
        repeat (k - cur) @(posedge clk);
        #1;
        cur = k;
    endtask

    task automatic pulse_load(input int k, input logic [15:0] v);
        at_edge(k - 1);
        load = 1'b1;
        din  = v;
        at_edge(k);
        load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        din      = 16'h0000;
        blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cur = 0;

        push_after_reset();
        push_frame(16'h1234, 16'h7BDE);
        push_frame(16'h0007, 16'h7BDE);
        push_frame(16'h0070, 16'hFFDE);
        push_frame(16'h0000, 16'hFFFE);
        push_frame(16'h0000, 16'h7BDE);
        push_frame(16'h2222, 16'h7BDE);
        push_frame(16'h3333, 16'h7BDE);
        push_slot(4'h3, 4'b1110, 1'b1);
        push1(4'h3, 4'b1111, 1'b0);
        push1(4'h3, 4'b1101, 1'b0);
        push_after_reset();
        push_frame(16'h0000, 16'h7BDE);
        rst = 1'b0;

        pulse_load(2,  16'h1234);
        pulse_load(22, 16'h0007);
        pulse_load(40, 16'h0070);
        at_edge(47);
        blank_lz = 1'b1;
        pulse_load(50, 16'h0000);
        at_edge(79);
        blank_lz = 1'b0;
        pulse_load(82,  16'h1111);
        pulse_load(86,  16'h2222);
        pulse_load(112, 16'h3333);
        pulse_load(130, 16'h5555);
        at_edge(133);
        rst  = 1'b1;
        load = 1'b1;
        din  = 16'h9999;
        at_edge(134);
        rst  = 1'b0;
        load = 1'b0;

        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
